// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register-file write side.
package regfile_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int SP_IDX    = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/regfile_write_port_if.sv
// Write-back handshake between the WB stage (master) and the register file (slave).
interface regfile_write_port_if #(
  parameter int XLEN = 32
);
  import regfile_pkg::*;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [REG_IDX_W-1:0] rd;
  logic [XLEN-1:0]      wd;

  modport master (output wb_valid, output rd, output wd, input  wb_ready);
  modport slave  (input  wb_valid, input  rd, input  wd, output wb_ready);
endinterface

// File: rtl/regfile_wr_decoder.sv
// Index-to-one-hot write-enable decoder, shared by the init sweep and the write path.
module regfile_wr_decoder
  import regfile_pkg::*;
(
  input  logic                 en,
  input  logic [REG_IDX_W-1:0] idx,
  output logic [NUM_REGS-1:0]  we
);

  // One-hot enable for the selected register, all-zero when disabled
  always_comb begin
    we = '0;
    if (en) we[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x XLEN integer register file.
// Optional feature macro: REGFILE_BYPASS_EN forwards an accepted write's data
// straight onto the matching Xn output in the same cycle.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  regfile_write_port_if.slave   wb,
  output logic                  init_done,
  output logic [XLEN-1:0]       X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
  output logic [XLEN-1:0]       X8,  X9,  X10, X11, X12, X13, X14, X15,
  output logic [XLEN-1:0]       X16, X17, X18, X19, X20, X21, X22, X23,
  output logic [XLEN-1:0]       X24, X25, X26, X27, X28, X29, X30, X31
);

  state_e               state_q;
  logic [REG_IDX_W-1:0] idx_q;
  logic                 init_done_q;

  logic                 in_clear;
  logic                 wr_fire;
  logic                 sel_en;
  logic [REG_IDX_W-1:0] sel_idx;
  logic [XLEN-1:0]      sel_data;
  logic [NUM_REGS-1:0]  we;
  logic                 unused_we0;

  // x0 has no storage, so only entries 1..31 exist
  logic [XLEN-1:0]      regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0]      regs_d [1:NUM_REGS-1];
  logic [XLEN-1:0]      xout   [NUM_REGS];

  assign in_clear    = (state_q == CLEAR);
  // clear_req wins over a same-cycle write by withholding ready
  assign wb.wb_ready = (state_q == RUN) && !clear_req;
  assign wr_fire     = wb.wb_valid && wb.wb_ready;
  assign init_done   = init_done_q;
  assign unused_we0  = we[0];

  // Sweep and write path never overlap, so one decoder serves both
  always_comb begin
    sel_en   = wr_fire;
    sel_idx  = wb.rd;
    sel_data = wb.wd;
    if (in_clear) begin
      sel_en   = rst_n;
      sel_idx  = idx_q;
      sel_data = (idx_q == REG_IDX_W'(SP_IDX)) ? SP_INIT : '0;
    end
  end

  regfile_wr_decoder u_dec (
    .en  (sel_en),
    .idx (sel_idx),
    .we  (we)
  );

  // Sequencer: sweep all indices after reset or clear, then accept writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          idx_q <= idx_q + REG_IDX_W'(1);
          if (idx_q == REG_IDX_W'(NUM_REGS - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state_q     <= CLEAR;
            idx_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Next storage contents: the enabled entry takes the selected data
  always_comb begin
    regs_d = regs_q;
    for (int n = 1; n < NUM_REGS; n++) begin
      if (we[n]) regs_d[n] = sel_data;
    end
  end

  // Storage has no reset term; the sweep is what initialises it
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Architectural view of the registers, x0 hard-wired to zero
  always_comb begin
    xout[0] = '0;
    for (int n = 1; n < NUM_REGS; n++) begin
      xout[n] = regs_q[n];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (wb.rd == REG_IDX_W'(n))) xout[n] = wb.wd;
`endif
    end
  end

  assign X0  = xout[0];  assign X1  = xout[1];  assign X2  = xout[2];  assign X3  = xout[3];
  assign X4  = xout[4];  assign X5  = xout[5];  assign X6  = xout[6];  assign X7  = xout[7];
  assign X8  = xout[8];  assign X9  = xout[9];  assign X10 = xout[10]; assign X11 = xout[11];
  assign X12 = xout[12]; assign X13 = xout[13]; assign X14 = xout[14]; assign X15 = xout[15];
  assign X16 = xout[16]; assign X17 = xout[17]; assign X18 = xout[18]; assign X19 = xout[19];
  assign X20 = xout[20]; assign X21 = xout[21]; assign X22 = xout[22]; assign X23 = xout[23];
  assign X24 = xout[24]; assign X25 = xout[25]; assign X26 = xout[26]; assign X27 = xout[27];
  assign X28 = xout[28]; assign X29 = xout[29]; assign X30 = xout[30]; assign X31 = xout[31];

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the 32 x 32-bit integer register file. Accepts write-back requests from the WB stage over a valid/ready handshake, decodes the destination index, and holds the 32 architectural registers. The registers drive the flat X0..X31 outputs consumed by the read-port multiplexers. After reset, or on request, an internal sequencer sweeps every register to its initial value before any write is accepted.

## Interface
- XLEN, 32, data width of each register
- SP_INIT, 32'h0000_3FFC, initial value written to x2 (sp) by the sweep; every other register sweeps to 0
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset
- clear_req  input  1  one-cycle pulse that restarts the init sweep while in RUN
- wb_valid  input  1  write-back request valid
- wb_ready  output  1  block can accept a write this cycle
- rd  input  5  destination register index
- wd  input  XLEN  write data
- init_done  output  1  high once the sweep completes; low during CLEAR
- X0..X31  output  XLEN each  current register contents, X0 always 0

## Operation
- FSM states are CLEAR and RUN. Reset enters CLEAR with sweep index = 0.
- CLEAR: on each cycle, write register[idx] with SP_INIT if idx==2, else 0, then idx++. After idx==31 is written, go to RUN. wb_ready=0 and init_done=0 throughout.
- RUN: wb_ready = !clear_req, combinational. A write is accepted on any edge where wb_valid && wb_ready; register[rd] takes wd at that edge.
- rd==0: the write is accepted (handshake completes) and the data is discarded. X0 is tied to 0 in all states.
- clear_req in RUN: has priority over a simultaneous write. That write is not accepted because wb_ready is low, and the WB stage must hold it. The FSM goes to CLEAR with idx=0.
- clear_req in CLEAR: ignored; the sweep continues without restarting.
- rst_n low at any time, including mid-sweep: next state is CLEAR with idx=0 and init_done=0. Register storage has no reset term; it is overwritten only by the sweep.
- wb_valid must stay asserted with stable rd/wd until accepted. The block has no internal write buffer.
- Back-to-back writes are allowed every cycle in RUN, including writes to the same index; the last one wins.

## Timing
- Reset values: wb_ready=0, init_done=0. X0=0. X1..X31 are unspecified until swept.
- Sweep: the first edge with rst_n=1 writes idx 0, and edge 31 writes idx 31. init_done and wb_ready are high from cycle 32, so the first write is accepted at edge 32.
- Write latency: new value is visible on Xn one cycle after the accepting edge (without bypass).
- After a clear_req edge, wb_ready drops for exactly 32 cycles.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Xn = wd combinationally when wb_valid && wb_ready && rd==n && n!=0, giving 0-cycle write-to-read visibility.
  - wb_ready must not combinationally depend on Xn.
- Not defined: Xn reflects storage only, with 1-cycle write latency as above.
- Handshake and sweep behaviour are identical in both builds.

## Structure
- Package regfile_pkg holds:
  - NUM_REGS=32, REG_IDX_W=5, SP_IDX=2
  - state enum (CLEAR, RUN)
- Sub-module regfile_wr_decoder maps a 5-bit index plus an enable to a 32-bit one-hot write-enable vector. It is shared by the sweep path (index = idx) and the write path (index = rd).

## Test plan
- Reset release: hold rst_n=0 for 3 cycles, then release. wb_ready=0 for 32 cycles. At cycle 32 init_done=1, X2=32'h0000_3FFC, and X1, X3..X31 are 0.
- Basic write: rd=5, wd=32'hDEAD_BEEF, valid for one cycle in RUN. Accepted at the edge; X5=32'hDEAD_BEEF the next cycle (same cycle with bypass).
- x0 discard: rd=0, wd=32'hFFFF_FFFF. Handshake completes and X0 stays 0.
- Clear collision: clear_req=1 together with wb_valid, rd=7, wd=1. Write not accepted and X7 unchanged. wb_ready=0 for 32 cycles; then X7=0, and the held write is accepted at the next ready edge.
- Mid-sweep reset: pulse rst_n=0 at sweep cycle 15. The sweep restarts at idx 0, and init_done rises 32 cycles after release.
- Streaming: write 31 consecutive cycles to rd=1..31 with wd=rd*3. The bench sees no stall; every Xn equals n*3 afterwards, with X2 overwritten to 6.
